turf_acknack_arbiter: RTL and testbench
=======================================

TURF_ACKNACK_ARBITER -- requirements
Module: turf_acknack_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 1024, the maximum cycles DATA may wait for a source data beat before abort.
REQ-002 The port aclk, input, 1 bit, SHALL be the single clock.
REQ-003 The port aresetn, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-004 The ports s0_udphdr_tdata/tvalid/tready, 64/1/1 bits, target, SHALL carry the ACK port response header.
REQ-005 The ports s0_udpdata_tdata/tkeep/tlast/tvalid/tready, 64/8/1/1/1 bits, target, SHALL carry the ACK port response data.
REQ-006 The ports s1_udphdr_* and s1_udpdata_* SHALL be identical to REQ-004 and REQ-005 and SHALL carry the NACK port response.
REQ-007 The ports m_udphdr_tdata/tvalid/tready, 64/1/1 bits, host, SHALL carry the merged header to the UDP transmitter.
REQ-008 The ports m_udpdata_tdata/tkeep/tlast/tvalid/tready, 64/8/1/1/1 bits, host, SHALL carry the merged data.
REQ-009 The ports s0_acknack_* and s1_acknack_*, tdata/tvalid/tready 16/1/1 bits, target, SHALL carry ACK and NACK frame-buffer commands: tdata[15] allow, tdata[11:0] addr.
REQ-010 The ports m_acknack_tdata/tvalid/tready, 17/1/1 bits, host, SHALL carry the merged command: [15:0] the source tdata, [16] the source (0 ACK, 1 NACK).
REQ-011 The ports abort_count_o, 16 bits, output, SHALL carry a saturating count of timeout aborts.

Function
REQ-012 The response path SHALL use an FSM with states IDLE, HDR, DATA and FLUSH.
REQ-013 In IDLE, when any s*_udphdr_tvalid is high, the FSM SHALL register grant and move to HDR; if both are high, grant SHALL be the source other than last_grant.
REQ-014 In IDLE, all s*_udphdr_tready and s*_udpdata_tready SHALL be 0.
REQ-015 In HDR, m_udphdr_tvalid/tdata SHALL equal the granted source's, the granted s_udphdr_tready SHALL equal m_udphdr_tready, and the other source SHALL be held; a handshake SHALL move the FSM to DATA.
REQ-016 In DATA, the granted data stream SHALL pass combinationally to m_udpdata_*; a handshake with tlast SHALL update last_grant to grant and return the FSM to IDLE.
REQ-017 Header-to-output latency SHALL be exactly 1 cycle from IDLE.
REQ-018 A packet, header plus all data beats, SHALL never interleave with the other source.
REQ-019 In DATA, a timeout counter SHALL reset on every data handshake and count cycles in which the granted s_udpdata_tvalid is low.
REQ-020 When the counter reaches TIMEOUT, the block SHALL drive one m_udpdata beat with tdata 0, tkeep 8'h00 and tlast 1, increment abort_count_o (saturating at 16'hFFFF), and enter FLUSH.
REQ-021 In FLUSH, the granted source's data SHALL be accepted (tready 1) and discarded until a tlast handshake, then the FSM SHALL return to IDLE with last_grant updated.
REQ-022 The acknack merge SHALL be independent of the response FSM: a 1-entry output register.
REQ-023 The acknack merge SHALL accept a source only when the register is empty, or is full and m_acknack_tready is 1.
REQ-024 The acknack merge SHALL use its own round-robin pointer, updated on each accept.
REQ-025 Acknack latency SHALL be 1 cycle, with full throughput of 1 command per cycle under continuous m_acknack_tready.
REQ-026 Only the selected acknack source SHALL see tready 1; simultaneous valid commands SHALL alternate 0,1,0,1.
REQ-027 A held m_acknack_tvalid/tdata SHALL stay stable until handshake.

Reset
REQ-028 While aresetn is low: FSM in IDLE, last_grant 1 (so source 0 wins first), acknack pointer 1, output register empty, all tvalid/tready outputs 0, abort_count_o 0, timeout counter 0.
REQ-029 Reset mid-packet SHALL abandon the packet with no flush beat emitted; deassertion SHALL be synchronized internally to aclk.

Structure
REQ-030 The FSM state encoding, source index constants (SRC_ACK=0, SRC_NACK=1) and the acknack field positions SHALL live in a shared turf package.
REQ-031 The acknack merge SHALL be a sub-module, turf_acknack_merge, instantiated once.

Verification
REQ-032 Both headers valid on the same cycle after reset -> ACK packet (header plus 2 beats, tkeep FF/FF) is output first, then NACK, with no interleave.
REQ-033 Three back-to-back packets from source 1 only -> all three are forwarded; m_udphdr_tvalid rises 1 cycle after each s1_udphdr_tvalid.
REQ-034 Source 0 header accepted, data withheld for TIMEOUT=16 cycles -> flush beat (tkeep 00, tlast 1) is emitted, abort_count_o=1, and a later 2-beat source-0 data is discarded.
REQ-035 Both acknack sources valid for 8 cycles, tready 1 -> m_acknack_tdata[16] sequence 0,1,0,1,0,1,0,1 with 1 output per cycle.
REQ-036 m_acknack_tready held 0 with s0 tdata 16'h8123 -> output holds 17'h08123 stable and s0/s1 tready stay 0 until release.
REQ-037 aresetn pulsed low in DATA mid-packet -> all outputs are 0 within the reset, and the next packet starts cleanly from source 0.

Source files
------------

// File: rtl/turf_acknack_arbiter_pkg.sv
// Shared definitions for the TURF ACK/NACK arbiter: response FSM state
// encoding, source indices, acknack command field positions and the
// two-way round-robin pick used by both arbitration points.
package turf_acknack_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HDR   = 2'd1,
      ST_DATA  = 2'd2,
      ST_FLUSH = 2'd3
   } rsp_state_t;

   localparam logic SRC_ACK  = 1'b0;
   localparam logic SRC_NACK = 1'b1;

   localparam int ACKNACK_W         = 16;
   localparam int ACKNACK_ALLOW_BIT = 15;
   localparam int ACKNACK_ADDR_W    = 12;
   localparam int ACKNACK_SRC_BIT   = 16;
   localparam int M_ACKNACK_W       = 17;

   // Single requester wins outright; on a tie the source that did not win
   // last time is chosen.
   function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
      if (v0 && v1) return ~last;
      else if (v1)  return SRC_NACK;
      else          return SRC_ACK;
   endfunction

   function automatic logic [ACKNACK_W-1:0] acknack_cmd(input logic allow,
                                                        input logic [ACKNACK_ADDR_W-1:0] addr);
      logic [ACKNACK_W-1:0] w;
      w = '0;
      w[ACKNACK_ALLOW_BIT]     = allow;
      w[ACKNACK_ADDR_W-1:0]    = addr;
      return w;
   endfunction

endpackage

// File: rtl/turf_acknack_merge.sv
// Two-into-one merge of ACK/NACK frame-buffer commands through a 1-entry
// output register with its own round-robin pointer.
// Ports:
//   aclk, rst_n          clock, internally synchronized active-low reset
//   s0_* / s1_*          ACK / NACK command streams (16-bit tdata)
//   m_*                  merged stream, tdata[16] = source, [15:0] = command
module turf_acknack_merge
   import turf_acknack_arbiter_pkg::*;
(
   input  logic                   aclk,
   input  logic                   rst_n,
   input  logic [ACKNACK_W-1:0]   s0_tdata,
   input  logic                   s0_tvalid,
   output logic                   s0_tready,
   input  logic [ACKNACK_W-1:0]   s1_tdata,
   input  logic                   s1_tvalid,
   output logic                   s1_tready,
   output logic [M_ACKNACK_W-1:0] m_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready
);

   logic sel;
   logic load;
   logic rr_last_q;

   assign sel  = rr_pick(s0_tvalid, s1_tvalid, rr_last_q);
   // Gating with rst_n keeps every tready low for the whole reset window.
   assign load = rst_n && (s0_tvalid || s1_tvalid) && (!m_tvalid || m_tready);

   assign s0_tready = load && (sel == SRC_ACK);
   assign s1_tready = load && (sel == SRC_NACK);

   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         m_tvalid  <= 1'b0;
         m_tdata   <= '0;
         rr_last_q <= SRC_NACK;
      end else if (load) begin
         m_tvalid                  <= 1'b1;
         m_tdata[ACKNACK_SRC_BIT]  <= sel;
         m_tdata[ACKNACK_W-1:0]    <= (sel == SRC_NACK) ? s1_tdata : s0_tdata;
         rr_last_q                 <= sel;
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/turf_acknack_arbiter.sv
// Merges the ACK and NACK response packet streams (header + data) onto one
// UDP transmitter port without interleaving, aborts a packet whose data
// stalls for TIMEOUT cycles, and merges the two acknack command streams.
//
// state | meaning
// IDLE  | no packet owned; pick a source when any header is valid
// HDR   | forwarding the granted header
// DATA  | forwarding granted data beats; stall timer running
// FLUSH | abort beat sent; draining granted source up to its tlast
//
// Ports:
//   aclk, aresetn              clock, async active-low reset
//   s0_udphdr_* / s0_udpdata_* ACK response header / data
//   s1_udphdr_* / s1_udpdata_* NACK response header / data
//   m_udphdr_* / m_udpdata_*   merged response to the UDP transmitter
//   s0/s1/m_acknack_*          acknack command merge
//   abort_count_o              saturating count of timeout aborts
module turf_acknack_arbiter
   import turf_acknack_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [63:0]            s0_udphdr_tdata,
   input  logic                   s0_udphdr_tvalid,
   output logic                   s0_udphdr_tready,
   input  logic [63:0]            s0_udpdata_tdata,
   input  logic [7:0]             s0_udpdata_tkeep,
   input  logic                   s0_udpdata_tlast,
   input  logic                   s0_udpdata_tvalid,
   output logic                   s0_udpdata_tready,
   input  logic [63:0]            s1_udphdr_tdata,
   input  logic                   s1_udphdr_tvalid,
   output logic                   s1_udphdr_tready,
   input  logic [63:0]            s1_udpdata_tdata,
   input  logic [7:0]             s1_udpdata_tkeep,
   input  logic                   s1_udpdata_tlast,
   input  logic                   s1_udpdata_tvalid,
   output logic                   s1_udpdata_tready,
   output logic [63:0]            m_udphdr_tdata,
   output logic                   m_udphdr_tvalid,
   input  logic                   m_udphdr_tready,
   output logic [63:0]            m_udpdata_tdata,
   output logic [7:0]             m_udpdata_tkeep,
   output logic                   m_udpdata_tlast,
   output logic                   m_udpdata_tvalid,
   input  logic                   m_udpdata_tready,
   input  logic [ACKNACK_W-1:0]   s0_acknack_tdata,
   input  logic                   s0_acknack_tvalid,
   output logic                   s0_acknack_tready,
   input  logic [ACKNACK_W-1:0]   s1_acknack_tdata,
   input  logic                   s1_acknack_tvalid,
   output logic                   s1_acknack_tready,
   output logic [M_ACKNACK_W-1:0] m_acknack_tdata,
   output logic                   m_acknack_tvalid,
   input  logic                   m_acknack_tready,
   output logic [15:0]            abort_count_o
);

   localparam int                CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  TMO_LOAD = CNT_W'(TIMEOUT);

   // Assert asynchronously, release two aclk edges after aresetn rises.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   rsp_state_t       state_q, state_nxt;
   logic             grant_q, grant_nxt;
   logic             last_grant_q, last_grant_nxt;
   logic [CNT_W-1:0] tmo_q;
   logic             hdr_ready, dat_ready, abort_fire;

   logic        g_hdr_tvalid;
   logic [63:0] g_hdr_tdata;
   logic        g_dat_tvalid, g_dat_tlast;
   logic [63:0] g_dat_tdata;
   logic [7:0]  g_dat_tkeep;

   assign g_hdr_tvalid = (grant_q == SRC_NACK) ? s1_udphdr_tvalid  : s0_udphdr_tvalid;
   assign g_hdr_tdata  = (grant_q == SRC_NACK) ? s1_udphdr_tdata   : s0_udphdr_tdata;
   assign g_dat_tvalid = (grant_q == SRC_NACK) ? s1_udpdata_tvalid : s0_udpdata_tvalid;
   assign g_dat_tdata  = (grant_q == SRC_NACK) ? s1_udpdata_tdata  : s0_udpdata_tdata;
   assign g_dat_tkeep  = (grant_q == SRC_NACK) ? s1_udpdata_tkeep  : s0_udpdata_tkeep;
   assign g_dat_tlast  = (grant_q == SRC_NACK) ? s1_udpdata_tlast  : s0_udpdata_tlast;

   always_comb begin
      state_nxt        = state_q;
      grant_nxt        = grant_q;
      last_grant_nxt   = last_grant_q;
      hdr_ready        = 1'b0;
      dat_ready        = 1'b0;
      abort_fire       = 1'b0;
      m_udphdr_tvalid  = 1'b0;
      m_udphdr_tdata   = '0;
      m_udpdata_tvalid = 1'b0;
      m_udpdata_tdata  = '0;
      m_udpdata_tkeep  = '0;
      m_udpdata_tlast  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s0_udphdr_tvalid || s1_udphdr_tvalid) begin
               grant_nxt = rr_pick(s0_udphdr_tvalid, s1_udphdr_tvalid, last_grant_q);
               state_nxt = ST_HDR;
            end
         end
         ST_HDR: begin
            m_udphdr_tvalid = g_hdr_tvalid;
            m_udphdr_tdata  = g_hdr_tdata;
            hdr_ready       = m_udphdr_tready;
            if (g_hdr_tvalid && m_udphdr_tready) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (tmo_q == '0) begin
               // Stall expired: emit an empty terminating beat instead of source data.
               m_udpdata_tvalid = 1'b1;
               m_udpdata_tlast  = 1'b1;
               if (m_udpdata_tready) begin
                  abort_fire = 1'b1;
                  state_nxt  = ST_FLUSH;
               end
            end else begin
               m_udpdata_tvalid = g_dat_tvalid;
               m_udpdata_tdata  = g_dat_tdata;
               m_udpdata_tkeep  = g_dat_tkeep;
               m_udpdata_tlast  = g_dat_tlast;
               dat_ready        = m_udpdata_tready;
               if (g_dat_tvalid && m_udpdata_tready && g_dat_tlast) begin
                  state_nxt      = ST_IDLE;
                  last_grant_nxt = grant_q;
               end
            end
         end
         ST_FLUSH: begin
            dat_ready = 1'b1;
            if (g_dat_tvalid && g_dat_tlast) begin
               state_nxt      = ST_IDLE;
               last_grant_nxt = grant_q;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign s0_udphdr_tready  = hdr_ready && (grant_q == SRC_ACK);
   assign s1_udphdr_tready  = hdr_ready && (grant_q == SRC_NACK);
   assign s0_udpdata_tready = dat_ready && (grant_q == SRC_ACK);
   assign s1_udpdata_tready = dat_ready && (grant_q == SRC_NACK);

   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= SRC_ACK;
         last_grant_q <= SRC_NACK;
      end else begin
         state_q      <= state_nxt;
         grant_q      <= grant_nxt;
         last_grant_q <= last_grant_nxt;
      end
   end

   // Stall timer: loaded on header accept and on every data beat, decremented
   // on cycles with no granted data; terminal count is zero.
   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= '0;
      end else if (state_q == ST_HDR && g_hdr_tvalid && m_udphdr_tready) begin
         tmo_q <= TMO_LOAD;
      end else if (state_q == ST_DATA && tmo_q != '0) begin
         if (g_dat_tvalid && m_udpdata_tready) tmo_q <= TMO_LOAD;
         else if (!g_dat_tvalid)               tmo_q <= tmo_q - CNT_W'(1);
      end
   end

   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n)                                       abort_count_o <= '0;
      else if (abort_fire && abort_count_o != 16'hFFFF) abort_count_o <= abort_count_o + 16'd1;
   end

   turf_acknack_merge u_acknack_merge (
      .aclk      (aclk),
      .rst_n     (rst_n),
      .s0_tdata  (s0_acknack_tdata),
      .s0_tvalid (s0_acknack_tvalid),
      .s0_tready (s0_acknack_tready),
      .s1_tdata  (s1_acknack_tdata),
      .s1_tvalid (s1_acknack_tvalid),
      .s1_tready (s1_acknack_tready),
      .m_tdata   (m_acknack_tdata),
      .m_tvalid  (m_acknack_tvalid),
      .m_tready  (m_acknack_tready)
   );

endmodule

// File: tb/tb_turf_acknack_arbiter.sv
// Directed bench for turf_acknack_arbiter: reset state, packet arbitration,
// timeout abort/flush, acknack merge ordering and backpressure, mid-packet reset.
module tb_turf_acknack_arbiter;
   import turf_acknack_arbiter_pkg::*;

   localparam int TMO = 16;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [63:0] s0_udphdr_tdata, s1_udphdr_tdata, m_udphdr_tdata;
   logic        s0_udphdr_tvalid, s1_udphdr_tvalid, m_udphdr_tvalid;
   logic        s0_udphdr_tready, s1_udphdr_tready, m_udphdr_tready;
   logic [63:0] s0_udpdata_tdata, s1_udpdata_tdata, m_udpdata_tdata;
   logic [7:0]  s0_udpdata_tkeep, s1_udpdata_tkeep, m_udpdata_tkeep;
   logic        s0_udpdata_tlast, s1_udpdata_tlast, m_udpdata_tlast;
   logic        s0_udpdata_tvalid, s1_udpdata_tvalid, m_udpdata_tvalid;
   logic        s0_udpdata_tready, s1_udpdata_tready, m_udpdata_tready;
   logic [15:0] s0_acknack_tdata, s1_acknack_tdata;
   logic        s0_acknack_tvalid, s1_acknack_tvalid, m_acknack_tvalid;
   logic        s0_acknack_tready, s1_acknack_tready, m_acknack_tready;
   logic [16:0] m_acknack_tdata;
   logic [15:0] abort_count_o;

   int vectors     = 0;
   int miscompares = 0;

   always #5 aclk = ~aclk;

   turf_acknack_arbiter #(.TIMEOUT(TMO)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s0_udphdr_tdata(s0_udphdr_tdata), .s0_udphdr_tvalid(s0_udphdr_tvalid), .s0_udphdr_tready(s0_udphdr_tready),
      .s0_udpdata_tdata(s0_udpdata_tdata), .s0_udpdata_tkeep(s0_udpdata_tkeep), .s0_udpdata_tlast(s0_udpdata_tlast),
      .s0_udpdata_tvalid(s0_udpdata_tvalid), .s0_udpdata_tready(s0_udpdata_tready),
      .s1_udphdr_tdata(s1_udphdr_tdata), .s1_udphdr_tvalid(s1_udphdr_tvalid), .s1_udphdr_tready(s1_udphdr_tready),
      .s1_udpdata_tdata(s1_udpdata_tdata), .s1_udpdata_tkeep(s1_udpdata_tkeep), .s1_udpdata_tlast(s1_udpdata_tlast),
      .s1_udpdata_tvalid(s1_udpdata_tvalid), .s1_udpdata_tready(s1_udpdata_tready),
      .m_udphdr_tdata(m_udphdr_tdata), .m_udphdr_tvalid(m_udphdr_tvalid), .m_udphdr_tready(m_udphdr_tready),
      .m_udpdata_tdata(m_udpdata_tdata), .m_udpdata_tkeep(m_udpdata_tkeep), .m_udpdata_tlast(m_udpdata_tlast),
      .m_udpdata_tvalid(m_udpdata_tvalid), .m_udpdata_tready(m_udpdata_tready),
      .s0_acknack_tdata(s0_acknack_tdata), .s0_acknack_tvalid(s0_acknack_tvalid), .s0_acknack_tready(s0_acknack_tready),
      .s1_acknack_tdata(s1_acknack_tdata), .s1_acknack_tvalid(s1_acknack_tvalid), .s1_acknack_tready(s1_acknack_tready),
      .m_acknack_tdata(m_acknack_tdata), .m_acknack_tvalid(m_acknack_tvalid), .m_acknack_tready(m_acknack_tready),
      .abort_count_o(abort_count_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      s0_udphdr_tvalid = 1'b0;  s0_udphdr_tdata = '0;
      s1_udphdr_tvalid = 1'b0;  s1_udphdr_tdata = '0;
      s0_udpdata_tvalid = 1'b0; s0_udpdata_tdata = '0; s0_udpdata_tkeep = '0; s0_udpdata_tlast = 1'b0;
      s1_udpdata_tvalid = 1'b0; s1_udpdata_tdata = '0; s1_udpdata_tkeep = '0; s1_udpdata_tlast = 1'b0;
      s0_acknack_tvalid = 1'b0; s0_acknack_tdata = '0;
      s1_acknack_tvalid = 1'b0; s1_acknack_tdata = '0;
      m_udphdr_tready = 1'b1; m_udpdata_tready = 1'b1; m_acknack_tready = 1'b1;
   endtask

   task automatic set_hdr(input logic src, input logic v, input logic [63:0] d);
      if (src) begin s1_udphdr_tvalid = v; s1_udphdr_tdata = d; end
      else     begin s0_udphdr_tvalid = v; s0_udphdr_tdata = d; end
   endtask

   task automatic set_dat(input logic src, input logic v, input logic [63:0] d,
                          input logic [7:0] k, input logic l);
      if (src) begin s1_udpdata_tvalid = v; s1_udpdata_tdata = d; s1_udpdata_tkeep = k; s1_udpdata_tlast = l; end
      else     begin s0_udpdata_tvalid = v; s0_udpdata_tdata = d; s0_udpdata_tkeep = k; s0_udpdata_tlast = l; end
   endtask

   function automatic logic hdr_rdy(input logic src);
      return src ? s1_udphdr_tready : s0_udphdr_tready;
   endfunction

   function automatic logic dat_rdy(input logic src);
      return src ? s1_udpdata_tready : s0_udpdata_tready;
   endfunction

   // Starts from IDLE: header presented (optionally alongside the other
   // source's header), forwarded next cycle, then nb beats with tkeep FF.
   task automatic run_pkt(input logic src, input logic [63:0] hdr, input int nb,
                          input logic [63:0] dbase, input logic oth_v, input logic [63:0] oth_hdr);
      @(negedge aclk);
      set_dat(1'b0, 1'b0, '0, '0, 1'b0);
      set_dat(1'b1, 1'b0, '0, '0, 1'b0);
      set_hdr(src, 1'b1, hdr);
      set_hdr(~src, oth_v, oth_hdr);
      #1;
      chk("hdr_idle_valid", 64'(m_udphdr_tvalid), 64'd0);
      chk("hdr_idle_ready", 64'(hdr_rdy(src)), 64'd0);
      @(negedge aclk); #1;
      chk("hdr_valid", 64'(m_udphdr_tvalid), 64'd1);
      chk("hdr_data", m_udphdr_tdata, hdr);
      chk("hdr_ready", 64'(hdr_rdy(src)), 64'd1);
      chk("hdr_other_held", 64'(hdr_rdy(~src)), 64'd0);
      for (int b = 0; b < nb; b++) begin
         @(negedge aclk);
         set_hdr(src, 1'b0, '0);
         set_dat(src, 1'b1, dbase + 64'(b), 8'hFF, (b == nb - 1));
         #1;
         chk("dat_valid", 64'(m_udpdata_tvalid), 64'd1);
         chk("dat_data", m_udpdata_tdata, dbase + 64'(b));
         chk("dat_keep", 64'(m_udpdata_tkeep), 64'hFF);
         chk("dat_last", 64'(m_udpdata_tlast), (b == nb - 1) ? 64'd1 : 64'd0);
         chk("dat_ready", 64'(dat_rdy(src)), 64'd1);
         chk("dat_other_held", 64'(dat_rdy(~src)), 64'd0);
         chk("dat_other_hdr_held", 64'(hdr_rdy(~src)), 64'd0);
         chk("dat_no_hdr", 64'(m_udphdr_tvalid), 64'd0);
      end
   endtask

   task automatic idle_step();
      @(negedge aclk);
      clr();
      #1;
      chk("idle_no_data", 64'(m_udpdata_tvalid), 64'd0);
      chk("idle_no_hdr", 64'(m_udphdr_tvalid), 64'd0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_m_hdr_valid", 64'(m_udphdr_tvalid), 64'd0);
      chk("rst_m_dat_valid", 64'(m_udpdata_tvalid), 64'd0);
      chk("rst_m_ack_valid", 64'(m_acknack_tvalid), 64'd0);
      chk("rst_s0_hdr_ready", 64'(s0_udphdr_tready), 64'd0);
      chk("rst_s1_dat_ready", 64'(s1_udpdata_tready), 64'd0);
      chk("rst_s0_ack_ready", 64'(s0_acknack_tready), 64'd0);
      chk("rst_s1_ack_ready", 64'(s1_acknack_tready), 64'd0);
      chk("rst_abort_count", 64'(abort_count_o), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] cmd0, cmd1, cmd2, cmd3;
      int waited;
      bit found;

      // ---- reset state with inputs active ----
      aresetn = 1'b0;
      clr();
      s0_udphdr_tvalid = 1'b1;
      s1_udpdata_tvalid = 1'b1;
      s0_acknack_tvalid = 1'b1;
      s1_acknack_tvalid = 1'b1;
      repeat (3) @(negedge aclk);
      #1;
      check_reset_outputs();
      @(negedge aclk);
      clr();
      aresetn = 1'b1;
      repeat (3) @(negedge aclk);

      // ---- acknack: both valid for 8 cycles, alternate 0,1,0,1... ----
      cmd0 = acknack_cmd(1'b1, 12'h001);
      cmd1 = acknack_cmd(1'b0, 12'h002);
      for (int k = 0; k <= 8; k++) begin
         @(negedge aclk);
         s0_acknack_tvalid = (k < 8); s0_acknack_tdata = cmd0;
         s1_acknack_tvalid = (k < 8); s1_acknack_tdata = cmd1;
         m_acknack_tready  = 1'b1;
         #1;
         if (k < 8) begin
            chk("an_s0_ready", 64'(s0_acknack_tready), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("an_s1_ready", 64'(s1_acknack_tready), (k % 2 == 1) ? 64'd1 : 64'd0);
         end
         if (k == 0) begin
            chk("an_first_empty", 64'(m_acknack_tvalid), 64'd0);
         end else begin
            chk("an_valid", 64'(m_acknack_tvalid), 64'd1);
            chk("an_data", 64'(m_acknack_tdata), ((k - 1) % 2 == 1) ? 64'h10002 : 64'h08001);
         end
      end

      // ---- acknack: output held under backpressure ----
      cmd2 = acknack_cmd(1'b1, 12'h123);
      cmd3 = acknack_cmd(1'b0, 12'h456);
      @(negedge aclk);
      s0_acknack_tvalid = 1'b0; s1_acknack_tvalid = 1'b0;
      #1;
      chk("an_drained", 64'(m_acknack_tvalid), 64'd0);
      @(negedge aclk);
      m_acknack_tready  = 1'b0;
      s0_acknack_tvalid = 1'b1; s0_acknack_tdata = cmd2;
      #1;
      chk("an_bp_load_ready", 64'(s0_acknack_tready), 64'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge aclk);
         s0_acknack_tvalid = 1'b0;
         s1_acknack_tvalid = 1'b1; s1_acknack_tdata = cmd3;
         #1;
         chk("an_bp_valid", 64'(m_acknack_tvalid), 64'd1);
         chk("an_bp_hold", 64'(m_acknack_tdata), 64'h08123);
         chk("an_bp_s0_ready", 64'(s0_acknack_tready), 64'd0);
         chk("an_bp_s1_ready", 64'(s1_acknack_tready), 64'd0);
      end
      @(negedge aclk);
      m_acknack_tready = 1'b1;
      #1;
      chk("an_release_data", 64'(m_acknack_tdata), 64'h08123);
      chk("an_release_s1_ready", 64'(s1_acknack_tready), 64'd1);
      @(negedge aclk);
      s1_acknack_tvalid = 1'b0;
      #1;
      chk("an_next_data", 64'(m_acknack_tdata), 64'h10456);
      @(negedge aclk);
      #1;
      chk("an_empty", 64'(m_acknack_tvalid), 64'd0);

      // ---- both headers at once: ACK packet first, then NACK ----
      run_pkt(1'b0, 64'hA0A0_0000_0000_0A00, 2, 64'hD000_0000_0000_0000, 1'b1, 64'hB1B1_0000_0000_0B11);
      run_pkt(1'b1, 64'hB1B1_0000_0000_0B11, 2, 64'hD100_0000_0000_0000, 1'b0, 64'd0);
      idle_step();

      // ---- three back-to-back NACK-only packets ----
      run_pkt(1'b1, 64'hC001_0000_0000_0001, 1, 64'hE100_0000_0000_0000, 1'b0, 64'd0);
      run_pkt(1'b1, 64'hC002_0000_0000_0002, 2, 64'hE200_0000_0000_0000, 1'b0, 64'd0);
      run_pkt(1'b1, 64'hC003_0000_0000_0003, 3, 64'hE300_0000_0000_0000, 1'b0, 64'd0);
      idle_step();

      // ---- timeout abort on ACK, then flush of late data ----
      @(negedge aclk);
      set_hdr(1'b0, 1'b1, 64'hF00D_0000_0000_0000);
      @(negedge aclk); #1;
      chk("tmo_hdr_valid", 64'(m_udphdr_tvalid), 64'd1);
      waited = 0;
      found  = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge aclk);
         set_hdr(1'b0, 1'b0, '0);
         #1;
         if (m_udpdata_tvalid) found = 1'b1;
         else                  waited++;
      end
      chk("tmo_wait_cycles", 64'(waited), 64'd16);
      chk("tmo_beat_data", m_udpdata_tdata, 64'd0);
      chk("tmo_beat_keep", 64'(m_udpdata_tkeep), 64'h00);
      chk("tmo_beat_last", 64'(m_udpdata_tlast), 64'd1);
      chk("tmo_src_ready", 64'(s0_udpdata_tready), 64'd0);
      chk("tmo_count_before", 64'(abort_count_o), 64'd0);
      @(negedge aclk); #1;
      chk("tmo_count_after", 64'(abort_count_o), 64'd1);
      chk("flush_no_out", 64'(m_udpdata_tvalid), 64'd0);
      for (int b = 0; b < 2; b++) begin
         @(negedge aclk);
         set_dat(1'b0, 1'b1, 64'h1A7E_0000_0000_0000 + 64'(b), 8'hFF, (b == 1));
         #1;
         chk("flush_ready", 64'(s0_udpdata_tready), 64'd1);
         chk("flush_discard", 64'(m_udpdata_tvalid), 64'd0);
      end
      idle_step();
      chk("flush_done_ready", 64'(s0_udpdata_tready), 64'd0);
      chk("flush_count_kept", 64'(abort_count_o), 64'd1);

      // ---- reset mid-packet, then clean restart from ACK ----
      @(negedge aclk);
      set_hdr(1'b1, 1'b1, 64'h5EED_0000_0000_0001);
      @(negedge aclk); #1;
      chk("mid_hdr_valid", 64'(m_udphdr_tvalid), 64'd1);
      @(negedge aclk);
      set_hdr(1'b1, 1'b0, '0);
      set_dat(1'b1, 1'b1, 64'h5EED_0000_0000_00D0, 8'hFF, 1'b0);
      #1;
      chk("mid_dat_valid", 64'(m_udpdata_tvalid), 64'd1);
      @(negedge aclk);
      aresetn = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge aclk); #1;
      check_reset_outputs();
      @(negedge aclk);
      aresetn = 1'b1;
      clr();
      for (int c = 0; c < 3; c++) begin
         @(negedge aclk); #1;
         chk("post_rst_no_flush", 64'(m_udpdata_tvalid), 64'd0);
      end
      run_pkt(1'b0, 64'hA1A1_0000_0000_0001, 1, 64'hDD00_0000_0000_0000, 1'b1, 64'hB2B2_0000_0000_0002);
      idle_step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
